// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: DEPTH-entry fetch FIFO feeding a registered decode slot,
// with a one-cycle JAL redirect toward ifetch. Optional macro DECODE_ILLEGAL_EN adds out_illegal.
module decode_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [31:0]           in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_order,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [31:0]           out_imm,
  output logic [ADDR_WIDTH-1:0] out_pc,
`ifdef DECODE_ILLEGAL_EN
  output logic                  out_illegal,
`endif
  output logic                  redir_valid,
  output logic [ADDR_WIDTH-1:0] redir_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [31:0]           inst_mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic [ADDR_WIDTH-1:0] head_pc;
  logic [31:0]           head_inst;
  logic [6:0]            opc, f7;
  logic [2:0]            f3;
  logic [6:0]            d_order;
  logic [4:0]            d_rd, d_rs1, d_rs2;
  logic [31:0]           d_imm;
  logic                  d_jal;
  logic                  push, load, jal_load;
  logic [ADDR_WIDTH-1:0] jal_target;

  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // valid never depends on ready, and a held (valid && !ready) beat keeps its data stable.
  assign in_ready = rdy_in && (count != CW'(DEPTH)) && !redir_valid;
  assign push     = in_valid && in_ready;
  assign load     = rdy_in && (count != '0) && (!out_valid || out_ready);
  assign jal_load = load && d_jal;

  assign head_pc    = pc_mem[rd_ptr];
  assign head_inst  = inst_mem[rd_ptr];
  assign opc        = head_inst[6:0];
  assign f3         = head_inst[14:12];
  assign f7         = head_inst[31:25];
  assign jal_target = head_pc + ADDR_WIDTH'($signed(d_imm));

  always_comb begin
    d_order = '0;
    d_rd    = '0;
    d_rs1   = '0;
    d_rs2   = '0;
    d_imm   = '0;
    d_jal   = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC: begin
        d_order = opc;
        d_rd    = head_inst[11:7];
        d_imm   = {head_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        d_order = opc;
        d_rd    = head_inst[11:7];
        d_imm   = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20], head_inst[30:21], 1'b0};
        d_jal   = 1'b1;
      end
      OP_JALR, OP_LOAD: begin
        d_order = (opc == OP_JALR) ? opc : {opc[6:4], f3, 1'b0};
        d_rd    = head_inst[11:7];
        d_rs1   = head_inst[19:15];
        d_imm   = {{20{head_inst[31]}}, head_inst[31:20]};
      end
      OP_IMM: begin
        d_order = {opc[6:4], f3, head_inst[30] && (f3 == 3'b101)};
        d_rd    = head_inst[11:7];
        d_rs1   = head_inst[19:15];
        // Shift-immediates carry a 5-bit shamt, not a signed immediate.
        if (f3 == 3'b001 || f3 == 3'b101) d_imm = {27'b0, head_inst[24:20]};
        else                              d_imm = {{20{head_inst[31]}}, head_inst[31:20]};
      end
      OP_REG: begin
        d_order = {opc[6:4], f3, head_inst[30] && (f3 == 3'b000 || f3 == 3'b101)};
        d_rd    = head_inst[11:7];
        d_rs1   = head_inst[19:15];
        d_rs2   = head_inst[24:20];
      end
      OP_STORE: begin
        d_order = {opc[6:4], f3, 1'b0};
        d_rs1   = head_inst[19:15];
        d_rs2   = head_inst[24:20];
        d_imm   = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
      end
      OP_BRANCH: begin
        d_order = {opc[6:4], f3, 1'b0};
        d_rs1   = head_inst[19:15];
        d_rs2   = head_inst[24:20];
        d_imm   = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25], head_inst[11:8], 1'b0};
      end
      default: ;
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  logic d_illegal;

  always_comb begin
    d_illegal = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: d_illegal = 1'b0;
      OP_IMM: begin
        if (f3 == 3'b001)      d_illegal = (f7 != 7'h00);
        else if (f3 == 3'b101) d_illegal = !(f7 == 7'h00 || f7 == 7'h20);
      end
      OP_REG:    d_illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      OP_LOAD:   d_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OP_STORE:  d_illegal = (f3 >= 3'b011);
      OP_BRANCH: d_illegal = (f3 == 3'b010) || (f3 == 3'b011);
      default:   d_illegal = 1'b1;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      out_order   <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
`ifdef DECODE_ILLEGAL_EN
      out_illegal <= 1'b0;
`endif
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        count       <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        out_valid   <= 1'b0;
        redir_valid <= 1'b0;
      end else begin
        redir_valid <= jal_load;
        if (jal_load) redir_pc <= jal_target;

        if (load) begin
          out_valid   <= 1'b1;
          out_order   <= d_order;
          out_rd      <= d_rd;
          out_rs1     <= d_rs1;
          out_rs2     <= d_rs2;
          out_imm     <= d_imm;
          out_pc      <= head_pc;
`ifdef DECODE_ILLEGAL_EN
          out_illegal <= d_illegal;
`endif
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end

        // A JAL leaving the FIFO kills the wrong-path entries behind it and any same-edge push.
        if (jal_load) begin
          count  <= '0;
          rd_ptr <= wr_ptr;
        end else begin
          if (push) wr_ptr <= wr_ptr + PW'(1);
          if (load) rd_ptr <= rd_ptr + PW'(1);
          case ({push, load})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, handshaked RV32I decode stage between ifetch and dispatch.
- Instructions are pushed into a DEPTH-entry FIFO and decoded from the FIFO head into a registered output slot.
- Downstream sees a valid/ready stream of {orderType, rd, rs1, rs2, imm, pc}.
- Generates a JAL redirect toward ifetch, so ifetch no longer waits for execute on direct jumps.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
ADDR_WIDTH, 32, PC width

Ports:
clk  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; low freezes all state
flush_in  in  1  pipeline flush (mispredict/exception)
in_valid  in  1  ifetch offers instruction
in_ready  out  1  rdy_in && count<DEPTH && !redir_valid
in_pc  in  ADDR_WIDTH  PC of offered instruction
in_inst  in  32  raw instruction
out_valid  out  1  decoded slot occupied
out_ready  in  1  consumer accepts slot
out_order  out  7  orderType
out_rd  out  5  destination register
out_rs1  out  5  source 1
out_rs2  out  5  source 2
out_imm  out  32  immediate
out_pc  out  ADDR_WIDTH  PC of decoded instruction
redir_valid  out  1  one-cycle JAL redirect pulse
redir_pc  out  ADDR_WIDTH  JAL target

Behaviour:
- Reset (async, rst_n_in=0): FIFO count, pointers, out_valid and redir_valid go to 0; all data outputs go to 0.
- rdy_in=0: no push, no pop, no output change; in_ready=0; redir_valid holds its value.
- Push: in_valid && in_ready at posedge writes {in_pc, in_inst} at the tail.
- Full: no push while count==DEPTH, even if a pop occurs in the same cycle (no bypass).
- Load: the output slot loads from the head when count>0 && (!out_valid || out_ready). Otherwise it clears out_valid when out_ready && out_valid.
- Latency: minimum 2 edges from push to out_valid. No empty-FIFO bypass.
- Simultaneous push and load: count unchanged; pointers wrap modulo DEPTH.
- Output hold: slot contents stay stable while out_valid && !out_ready.
- orderType encoding:
  - LUI, AUIPC, JAL, JALR: order = opcode.
  - I/R/L/S/B: order = {opcode[6:4], funct3, alt}.
  - alt=1 only for SUB, SRA, SRAI, i.e. inst[30]=1 with funct3 000 (R only) or 101. Otherwise alt=0.
- Field rules:
  - rd is 0 for S/B.
  - rs1 is 0 for LUI/AUIPC/JAL.
  - rs2 is nonzero only for R/S/B.
- Immediates:
  - U: {inst[31:12], 12'b0}.
  - J: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - I (incl. JALR, SLTIU, loads): sign-extended inst[31:20]. JALR is not masked here.
  - Shifts: zero-extended inst[24:20].
  - S: sign-extended {inst[31:25], inst[11:7]}.
  - B: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- Unknown opcode: loaded with out_order=0 and rd/rs1/rs2/imm=0.
- JAL redirect, on the edge a JAL loads into the slot:
  - redir_valid=1 and redir_pc=pc+imm (mod 2^ADDR_WIDTH) for exactly one cycle.
  - All FIFO entries behind the JAL are discarded (count=0, pointers equal).
  - Any same-edge push is dropped.
  - in_ready is low while redir_valid=1.
- Flush, highest priority:
  - At a posedge with flush_in=1 && rdy_in=1: FIFO empties, out_valid=0, redir_valid=0.
  - Same-edge push, load and redirect are all ignored.
  - in_ready recovers the following cycle.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- Defined:
  - Adds output out_illegal (1 bit), registered with the slot, reset 0.
  - Set for:
    - unknown opcode;
    - load funct3 in {011, 110, 111};
    - store funct3 >= 011;
    - branch funct3 in {010, 011};
    - R-type funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101};
    - SLLI/SRLI/SRAI with bad inst[31:25].
  - An illegal instruction never triggers a redirect.
- Undefined:
  - Port absent.
  - Such encodings decode per the normal field rules; unknown opcode gives zeros.

Test Plan:
1. addi x1,x2,-1 (0xFFF10093) at pc 0x100 -> 2 edges later: out_valid=1, order=0010000, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, out_pc=0x100.
2. Push 5 instructions with out_ready=0, DEPTH=4 -> slot holds #1; in_ready=0 after 4 FIFO entries; #1 stays stable; set out_ready=1 -> in-order drain with no loss.
3. sub x3,x1,x2 (0x402081B3) -> order=0110001. srai x5,x5,3 (0x4032D293) -> order=0011011, imm=3.
4. jal x1,+0x20 at pc 0x200, followed by 2 queued instructions -> redir_valid pulses once with redir_pc=0x220; FIFO emptied; JAL out with rd=1, imm=0x20.
5. flush_in=1 with a full FIFO, the slot valid and in_valid=1 -> next cycle: out_valid=0, count 0, no push; in_ready=1 the cycle after.
6. Assert rst_n_in mid-stream between edges -> outputs are 0 immediately without a clock edge. With DECODE_ILLEGAL_EN, opcode 0x0000007F -> out_illegal=1, order=0.
